dmem_lsu: RTL and testbench

// Load/store unit for the single-cycle MIPS data path. It is the initiator side of the data-memory interface.

---
 rtl/dmem_lsu_pkg.sv | 66 ++++++
 rtl/dmem_lsu_align.sv | 19 +
 rtl/dmem_lsu.sv | 124 ++++++++++++
 tb/tb_dmem_lsu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
// Little-endian lane selection: byte lane = addr[1:0], half lane = addr[1].
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      SZ_WORD: r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane extract (loads) and lane merge (sub-word stores).
// Zero latency; no flow control.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] ext_word_i,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  assign ext_o    = lane_extract(ext_word_i, off_i, size_i, uns_i);
  assign merged_o = lane_merge(merge_word_i, wdata_i, off_i, size_i);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed, async-read data memory.
// Latency accept->rsp: error 1, load 2, word store 2, sub-word store 3 (read-modify-write).
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_we,
  input  logic [31:0]       mem_RD
);

  state_e state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rd_buf_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       ext_word;
  logic [31:0]       merged_word;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_idx = {2'b00, req_addr[ADDR_W-1:2]};

  // Out-of-range indices are rejected rather than wrapped into the memory.
  assign req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || (req_idx >= ADDR_W'(MEM_WORDS));

  dmem_lsu_align u_align (
    .ext_word_i   (mem_RD),
    .merge_word_i (rd_buf_q),
    .wdata_i      (wdata_q),
    .off_i        (addr_q[1:0]),
    .size_i       (size_q),
    .uns_i        (uns_q),
    .ext_o        (ext_word),
    .merged_o     (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                              state_d = RESP;
          else if (!req_we || req_size != SZ_WORD)  state_d = READ;
          else                                      state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_we    = (state_q == WRITE);
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
    mem_A     = '0;
    mem_WD    = 32'h0;
    if (state_q == READ || state_q == WRITE) mem_A = {2'b00, addr_q[ADDR_W-1:2]};
    if (state_q == WRITE) mem_WD = (size_q == SZ_WORD) ? wdata_q : merged_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rd_buf_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= 32'h0;
      end
      if (state_q == READ) begin
        rd_buf_q <= mem_RD;
        if (!we_q) rdata_q <= ext_word;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural async-read data memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;

  logic [31:0] mem [32];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_A(mem_A), .mem_WD(mem_WD), .mem_we(mem_we),
    .mem_RD(mem_RD)
  );

  assign mem_RD = (mem_A < 32) ? mem[mem_A[4:0]] : 32'hxxxx_xxxx;

  always @(posedge clk) begin
    if (mem_we && mem_A < 32) mem[mem_A[4:0]] <= mem_WD;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
  endtask

  // Issue one request and watch every cycle until its response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int we_cnt, output int we_cyc,
                        output logic [31:0] wa, output logic [31:0] wwd);
    int n;
    lat = 99; rdata = 32'hx; err = 1'bx; we_cnt = 0; we_cyc = 0; wa = 32'hx; wwd = 32'hx;
    set_req(we, sz, uns, addr, wd);
    req_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++; we_cyc = k; wa = mem_A; wwd = mem_WD;
      end
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  int          lat, wc, wcyc;
  logic [31:0] rd, wa, wwd;
  logic        er;
  logic [31:0] q_dat[$];
  logic        q_err[$];
  int          b2b_lat[4];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'h8899_AABB;
    mem[4] = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b1;
    set_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_mem_WD", mem_WD, 32'h0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. byte loads, signed and unsigned
    do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, lat, rd, er, wc, wcyc, wa, wwd);
    chk("lb_lat", lat, 2);
    chk("lb_data", rd, 32'hFFFF_FFAA);
    chk("lb_err", {31'b0, er}, 32'd0);
    chk("lb_no_write", wc, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, rd, er, wc, wcyc, wa, wwd);
    chk("lbu_data", rd, 32'h0000_00AA);

    // 2. half store via read-modify-write
    do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_1234, lat, rd, er, wc, wcyc, wa, wwd);
    chk("sh_lat", lat, 3);
    chk("sh_we_cnt", wc, 1);
    chk("sh_we_cycle", wcyc, 2);
    chk("sh_mem_A", wa, 32'd3);
    chk("sh_mem_WD", wwd, 32'h1234_AABB);
    chk("sh_rdata", rd, 32'h0);
    chk("sh_mem3", mem[3], 32'h1234_AABB);
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rd, er, wc, wcyc, wa, wwd);
    chk("lw_after_sh", rd, 32'h1234_AABB);
    chk("lw_lat", lat, 2);

    // 3. word store skips READ
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, wc, wcyc, wa, wwd);
    chk("sw_lat", lat, 2);
    chk("sw_we_cycle", wcyc, 1);
    chk("sw_we_cnt", wc, 1);
    chk("sw_mem_A", wa, 32'd4);
    chk("sw_mem4", mem[4], 32'hDEAD_BEEF);

    // 4. errors
    do_req(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0, lat, rd, er, wc, wcyc, wa, wwd);
    chk("err_half_lat", lat, 1);
    chk("err_half_err", {31'b0, er}, 32'd1);
    chk("err_half_rdata", rd, 32'h0);
    chk("err_half_we", wc, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, lat, rd, er, wc, wcyc, wa, wwd);
    chk("err_range_err", {31'b0, er}, 32'd1);
    chk("err_range_we", wc, 0);
    do_req(1'b1, 2'b11, 1'b0, 32'h0C, 32'h5555_5555, lat, rd, er, wc, wcyc, wa, wwd);
    chk("err_size_err", {31'b0, er}, 32'd1);
    chk("err_size_we", wc, 0);
    chk("err_size_mem3", mem[3], 32'h1234_AABB);

    // 5. back-to-back with req_valid held high
    b2b_lat = '{2, 3, 2, 1};
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n;
      case (i)
        0: set_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        1: set_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055);
        2: set_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        default: set_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0);
      endcase
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        if (rsp_valid) begin q_dat.push_back(rsp_rdata); q_err.push_back(rsp_err); end
        if (req_ready) break;
        n++;
      end
      if (i > 0) begin
        chk($sformatf("b2b_gap%0d", i), n, b2b_lat[i-1]);
        chk($sformatf("b2b_rsp_before%0d", i), q_dat.size(), i);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) begin q_dat.push_back(rsp_rdata); q_err.push_back(rsp_err); break; end
    end
    chk("b2b_count", q_dat.size(), 4);
    if (q_dat.size() == 4) begin
      chk("b2b_d0", q_dat[0], 32'h1234_AABB);
      chk("b2b_d1", q_dat[1], 32'h0);
      chk("b2b_d2", q_dat[2], 32'h0000_DEAD);
      chk("b2b_e3", {31'b0, q_err[3]}, 32'd1);
      chk("b2b_e0", {31'b0, q_err[0]}, 32'd0);
    end
    chk("b2b_mem4", mem[4], 32'hDEAD_55EF);

    // 6. reset during WRITE of a sub-word store
    set_req(1'b1, 2'b00, 1'b0, 32'h0C, 32'h0000_0077);
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst6_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst6_in_write", {31'b0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst6_we_drop", {31'b0, mem_we}, 32'd0);
    chk("rst6_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    chk("rst6_idle", {31'b0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst6_mem3", mem[3], 32'h1234_AABB);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rd, er, wc, wcyc, wa, wwd);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", rd, 32'h1234_AABB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
